reg_trace_monitor: RTL

//  Parametrised, synthesizable watch unit for processor register values (e.g. REG15).

---
 rtl/reg_trace_monitor.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/reg_trace_monitor.sv
// reg_trace_monitor
//   Watches NCH register buses and queues value changes into a show-ahead
//   event FIFO. Each entry is {cycle stamp, channel, value}. When several
//   channels differ in the same cycle, only the lowest-indexed one is queued.
//   The others follow on later cycles, in index order. The run stops after
//   TIMEOUT RUN cycles.
// Ports
//   clk        rising-edge clock
//   INT        synchronous active-low reset
//   watch_val  packed channel values, channel c = watch_val[c*WIDTH +: WIDTH]
//   rd_en      pop the head entry (ignored while rd_valid is 0)
//   rd_valid   FIFO non-empty
//   rd_data    head entry {stamp, ch, value}
//   ovf        sticky, set when a push was blocked by a full FIFO
//   done       run finished
//   cycle      RUN cycle count, frozen once done
module reg_trace_monitor #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 4,
  parameter int DEPTH   = 8,
  parameter int TSW     = 16,
  parameter int TIMEOUT = 3500,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int EW     = TSW + CHW + WIDTH
) (
  input  logic                 clk,
  input  logic                 INT,
  input  logic [NCH*WIDTH-1:0] watch_val,
  input  logic                 rd_en,
  output logic                 rd_valid,
  output logic [EW-1:0]        rd_data,
  output logic                 ovf,
  output logic                 done,
  output logic [TSW-1:0]       cycle
);

  localparam int AW  = $clog2(DEPTH);
  // The run length is counted separately so TIMEOUT may exceed 2^TSW.
  localparam int RCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RCW-1:0] LAST_RUN = RCW'(TIMEOUT - 1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             valid_q;
  logic             ovf_q;
  logic             done_q;
  logic [TSW-1:0]   cycle_q;
  logic [RCW-1:0]   run_cnt_q;

  logic             win_found_s;
  logic [CHW-1:0]   win_idx_s;
  logic [WIDTH-1:0] win_val_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;

  // Priority search: scanning downwards leaves the lowest differing channel.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_val_s   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (watch_val[c*WIDTH +: WIDTH] != shadow_q[c]) begin
        win_found_s = 1'b1;
        win_idx_s   = CHW'(c);
        win_val_s   = watch_val[c*WIDTH +: WIDTH];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // FIFO handshakes. A pop frees a slot in the same cycle, so a full FIFO still
  // accepts a push when it is being read.
  always_comb begin
    full_s  = (count_q == FULL_CNT);
    pop_s   = INT && rd_en && (count_q != '0);
    push_s  = INT && (state_q == S_RUN) && win_found_s && (!full_s || pop_s);
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control FSM, shadows, FIFO pointers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!INT) begin
      state_q   <= S_INIT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      cycle_q   <= '0;
      run_cnt_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        shadow_q[c] <= '0;
      end
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case (state_q)
        S_INIT: begin
          for (int c = 0; c < NCH; c++) begin
            shadow_q[c] <= watch_val[c*WIDTH +: WIDTH];
          end
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (win_found_s) begin
            if (push_s) begin
              shadow_q[win_idx_s] <= win_val_s;
            end else begin
              // Shadow stays stale so the change is retried next cycle.
              ovf_q <= 1'b1;
            end
          end
          if (run_cnt_q == LAST_RUN) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cycle_q   <= cycle_q + TSW'(1);
            run_cnt_q <= run_cnt_q + RCW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Event storage. It needs no reset because the FIFO pointers track validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cycle_q, win_idx_s, win_val_s};
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = mem_q[rd_ptr_q];
  assign ovf      = ovf_q;
  assign done     = done_q;
  assign cycle    = cycle_q;

endmodule
